// File: rtl/mac_stream_pkg.sv
// Shared types for the MAC operand stream transmitter.
package mac_stream_pkg;

  localparam int unsigned MAC_MIN_OPS = 3;
  localparam int unsigned MAC_WORD_W  = 32;

  typedef logic [MAC_WORD_W-1:0] mac_word_t;

  typedef struct packed {
    logic      last;
    mac_word_t data;
  } tx_entry_t;

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;

endpackage

// File: rtl/mac_tx_fifo.sv
// Synchronous FIFO of tx entries with occupancy and buffered-last counters.
module mac_tx_fifo
  import mac_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  tx_entry_t                  wr_entry,
  input  logic                       pop,
  output tx_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     pending_last
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  tx_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage array; contents are only observed once written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers, occupancy and count of buffered last-marked entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pending_last <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count        <= count + CW'(do_push) - CW'(do_pop);
      pending_last <= pending_last + CW'(do_push && wr_entry.last)
                                   - CW'(do_pop && head.last);
    end
  end

endmodule

// File: rtl/mac_stream_tx.sv
// Burst-forming transmitter: gap-free bursts separated by an idle cycle.
module mac_stream_tx
  import mac_stream_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MIN_START = 3,
  parameter int unsigned LENW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  input  logic            in_last,
  output logic            out_valid,
  output logic [31:0]     out_data,
  output logic            busy,
  output logic            burst_done,
  output logic [LENW-1:0] burst_len,
  output logic            short_burst,
  output logic            underrun
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  tx_entry_t       wr_entry;
  tx_entry_t       head;
  logic [CW-1:0]   count;
  logic [CW-1:0]   pending_last;
  logic            pop;

  tx_state_t       state, state_n;
  logic [LENW-1:0] len, len_n, len_inc, blen_n;
  logic            valid_n, done_n, short_n, under_n;
  mac_word_t       data_n;

  assign wr_entry = tx_entry_t'({in_last, in_data});
  assign in_ready = (count != CW'(DEPTH));
  assign busy     = (state != IDLE);
  assign len_inc  = (len == '1) ? len : len + LENW'(1);

  mac_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (in_valid),
    .wr_entry     (wr_entry),
    .pop          (pop),
    .head         (head),
    .count        (count),
    .pending_last (pending_last)
  );

  // Next-state, pop decision and status for the burst FSM.
  always_comb begin
    state_n = state;
    len_n   = len;
    pop     = 1'b0;
    valid_n = 1'b0;
    data_n  = out_data;
    done_n  = 1'b0;
    blen_n  = burst_len;
    short_n = 1'b0;
    under_n = 1'b0;
    case (state)
      IDLE: begin
        if (count >= CW'(MIN_START) || pending_last != '0) pop = 1'b1;
      end
      SEND: begin
        if (count != '0) begin
          pop = 1'b1;
        end else begin
          state_n = GAP;
          done_n  = 1'b1;
          under_n = 1'b1;
          blen_n  = len;
          short_n = (len < LENW'(MAC_MIN_OPS));
        end
      end
      GAP: begin
        len_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Length is zero on entry from IDLE, so len_inc also yields the first count.
    if (pop) begin
      valid_n = 1'b1;
      data_n  = head.data;
      len_n   = len_inc;
      state_n = head.last ? GAP : SEND;
      if (head.last) begin
        done_n  = 1'b1;
        blen_n  = len_inc;
        short_n = (len_inc < LENW'(MAC_MIN_OPS));
      end
    end
  end

  // State, length counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      burst_done  <= 1'b0;
      burst_len   <= '0;
      short_burst <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_n;
      len         <= len_n;
      out_valid   <= valid_n;
      out_data    <= data_n;
      burst_done  <= done_n;
      burst_len   <= blen_n;
      short_burst <= short_n;
      underrun    <= under_n;
    end
  end

endmodule

// File: tb/tb_mac_stream_tx.sv
// Bench for mac_stream_tx: hand vectors, full-FIFO ordering, random vs model.
module tb_mac_stream_tx;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MIN_START = 3;
  localparam int unsigned LENW      = 16;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_last;
  logic [31:0]     in_data;
  logic            in_ready, out_valid, busy, burst_done, short_burst, underrun;
  logic [31:0]     out_data;
  logic [LENW-1:0] burst_len;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_stream_tx #(.DEPTH(DEPTH), .MIN_START(MIN_START), .LENW(LENW)) dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .in_data (in_data), .in_last (in_last), .out_valid (out_valid),
    .out_data (out_data), .busy (busy), .burst_done (burst_done),
    .burst_len (burst_len), .short_burst (short_burst), .underrun (underrun)
  );

  // Reference model: queue-based buffer plus a burst mode (0 idle, 1 sending, 2 gap).
  logic [32:0] mq [$];
  int          m_st, m_len, m_blen;
  bit          m_v, m_done, m_short, m_under;
  logic [31:0] m_d;

  task automatic model_step(input bit r, input bit v, input logic [31:0] d, input bit l);
    bit          anylast, pop, push;
    logic [32:0] h;
    if (r) begin
      mq.delete();
      m_st = 0; m_len = 0; m_blen = 0; m_v = 0; m_d = '0;
      m_done = 0; m_short = 0; m_under = 0;
      return;
    end
    push    = v && (mq.size() != DEPTH);
    anylast = 0;
    foreach (mq[i]) if (mq[i][32]) anylast = 1;
    h = (mq.size() > 0) ? mq[0] : '0;
    m_v = 0; m_done = 0; m_short = 0; m_under = 0; pop = 0;
    case (m_st)
      0: if (mq.size() >= MIN_START || anylast) pop = 1;
      1: begin
        if (mq.size() > 0) pop = 1;
        else begin
          m_done = 1; m_under = 1; m_blen = m_len; m_short = (m_len < 3); m_st = 2;
        end
      end
      default: begin m_len = 0; m_st = 0; end
    endcase
    if (pop) begin
      m_v   = 1;
      m_d   = h[31:0];
      m_len = (m_len == 65535) ? m_len : m_len + 1;
      m_st  = 1;
      void'(mq.pop_front());
      if (h[32]) begin
        m_done = 1; m_blen = m_len; m_short = (m_len < 3); m_st = 2;
      end
    end
    if (push) mq.push_back({l, d});
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge, compare.
  task automatic cyc(input bit r, input bit v, input logic [31:0] d, input bit l);
    rst = r; in_valid = v; in_data = d; in_last = l;
    model_step(r, v, d, l);
    @(posedge clk);
    #1;
    check("m_valid", 64'(out_valid), 64'(m_v));
    check("m_data", 64'(out_data), 64'(m_d));
    check("m_done", 64'(burst_done), 64'(m_done));
    if (m_done) check("m_len", 64'(burst_len), 64'(m_blen));
    check("m_short", 64'(short_burst), 64'(m_short));
    check("m_underrun", 64'(underrun), 64'(m_under));
    check("m_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    check("m_busy", 64'(busy), 64'(m_st != 0));
  endtask

  typedef struct {
    bit          r, v;
    logic [31:0] d;
    bit          l, ev;
    logic [31:0] ed;
    bit          edone;
    int          elen;
    bit          es, eu;
  } vec_t;

  vec_t tab [$];

  task automatic t(input bit r, input bit v, input int d, input bit l, input bit ev,
                   input int ed, input bit edone, input int elen, input bit es, input bit eu);
    vec_t e;
    e.r = r; e.v = v; e.d = 32'(d); e.l = l; e.ev = ev; e.ed = 32'(ed);
    e.edone = edone; e.elen = elen; e.es = es; e.eu = eu;
    tab.push_back(e);
  endtask

  logic [31:0] seen [$];
  logic [31:0] outq [$];
  logic [63:0] mac;
  logic [31:0] nxt;
  bit          rdy_pre, saw_full;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;

    // reset (with a push attempt that must be ignored), then 2,3,4(last)
    t(1,1,99,0, 0,0, 0,0,0,0);
    t(0,1,2,0,  0,0, 0,0,0,0);
    t(0,1,3,0,  0,0, 0,0,0,0);
    t(0,1,4,1,  0,0, 0,0,0,0);
    t(0,0,0,0,  1,2, 0,0,0,0);
    t(0,0,0,0,  1,3, 0,0,0,0);
    t(0,0,0,0,  1,4, 1,3,0,0);
    t(0,0,0,0,  0,0, 0,0,0,0);
    t(0,0,0,0,  0,0, 0,0,0,0);
    // short burst 5,6(last)
    t(0,1,5,0,  0,0, 0,0,0,0);
    t(0,1,6,1,  0,0, 0,0,0,0);
    t(0,0,0,0,  1,5, 0,0,0,0);
    t(0,0,0,0,  1,6, 1,2,1,0);
    t(0,0,0,0,  0,0, 0,0,0,0);
    // 1,2,3 without last then stall: underrun on first idle cycle
    t(0,1,1,0,  0,0, 0,0,0,0);
    t(0,1,2,0,  0,0, 0,0,0,0);
    t(0,1,3,0,  0,0, 0,0,0,0);
    t(0,0,0,0,  1,1, 0,0,0,0);
    t(0,0,0,0,  1,2, 0,0,0,0);
    t(0,0,0,0,  1,3, 0,0,0,0);
    t(0,0,0,0,  0,0, 1,3,0,1);
    t(0,0,0,0,  0,0, 0,0,0,0);
    t(0,0,0,0,  0,0, 0,0,0,0);
    // back-to-back {1,2,3L} {4,5,6L}: one idle cycle between
    t(0,1,1,0,  0,0, 0,0,0,0);
    t(0,1,2,0,  0,0, 0,0,0,0);
    t(0,1,3,1,  0,0, 0,0,0,0);
    t(0,1,4,0,  1,1, 0,0,0,0);
    t(0,1,5,0,  1,2, 0,0,0,0);
    t(0,1,6,1,  1,3, 1,3,0,0);
    t(0,0,0,0,  0,0, 0,0,0,0);
    t(0,0,0,0,  1,4, 0,0,0,0);
    t(0,0,0,0,  1,5, 0,0,0,0);
    t(0,0,0,0,  1,6, 1,3,0,0);
    t(0,0,0,0,  0,0, 0,0,0,0);
    // reset during the second word of a 5-word burst
    t(0,1,1,0,  0,0, 0,0,0,0);
    t(0,1,2,0,  0,0, 0,0,0,0);
    t(0,1,3,0,  0,0, 0,0,0,0);
    t(0,1,4,0,  1,1, 0,0,0,0);
    t(0,1,5,1,  1,2, 0,0,0,0);
    t(1,0,0,0,  0,0, 0,0,0,0);
    t(0,0,0,0,  0,0, 0,0,0,0);
    t(0,0,0,0,  0,0, 0,0,0,0);

    foreach (tab[i]) begin
      cyc(tab[i].r, tab[i].v, tab[i].d, tab[i].l);
      check($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tab[i].ev));
      if (tab[i].ev) check($sformatf("v%0d_data", i), 64'(out_data), 64'(tab[i].ed));
      check($sformatf("v%0d_done", i), 64'(burst_done), 64'(tab[i].edone));
      if (tab[i].edone) check($sformatf("v%0d_len", i), 64'(burst_len), 64'(tab[i].elen));
      check($sformatf("v%0d_short", i), 64'(short_burst), 64'(tab[i].es));
      check($sformatf("v%0d_underrun", i), 64'(underrun), 64'(tab[i].eu));
      check($sformatf("v%0d_ready", i), 64'(in_ready), 64'(1));
      if (i == 0) begin
        check("reset_data", 64'(out_data), 64'(0));
        check("reset_len", 64'(burst_len), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
      end
      if (out_valid) seen.push_back(out_data);
      if (i == 6) begin
        mac = (seen.size() >= 3) ? 64'(seen[0]) * 64'(seen[1]) + 64'(seen[2]) : '0;
        check("mac_result", mac, 64'(10));
      end
    end

    // Full FIFO: source holds each single-word burst until accepted.
    cyc(1, 0, 0, 0);
    nxt = 32'd100;
    saw_full = 0;
    for (int k = 0; k < 60 && outq.size() < 8; k++) begin
      rdy_pre = in_ready;
      cyc(0, nxt < 32'd108, nxt, 1'b1);
      if (nxt < 32'd108 && rdy_pre) nxt = nxt + 32'd1;
      if (!in_ready) saw_full = 1;
      if (out_valid) outq.push_back(out_data);
    end
    check("full_seen", 64'(saw_full), 64'(1));
    check("full_count", 64'(outq.size()), 64'(8));
    foreach (outq[i]) check($sformatf("full_order%0d", i), 64'(outq[i]), 64'(100 + i));

    // Randomized traffic against the model.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 199) == 0, ($urandom % 4) != 0, $urandom, ($urandom % 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_stream_tx.md
Name: mac_stream_tx

Overview:
- Transmit end of the three-operand multiply-accumulate stream interface.
- Buffers operand words from an upstream valid/ready source and emits them as contiguous validi/data_in bursts for the MAC receiver.
- Guarantees each burst is gap-free and separated from the next by at least one idle cycle, so the receiver computes a*b+c over each burst.
- Reports per-burst status for scoreboarding.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 4
- MIN_START, 3, buffered words required before a burst starts without a last marker
- LENW, 16, width of the burst length counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  FIFO can accept a word (combinational from registered count: count != DEPTH)
- in_data  input  32  operand word
- in_last  input  1  word ends the current burst
- out_valid  output  1  drives the receiver's validi
- out_data  output  32  drives the receiver's data_in
- busy  output  1  state != IDLE
- burst_done  output  1  one-cycle pulse when a burst terminates
- burst_len  output  LENW  words sent in the burst; valid while burst_done=1
- short_burst  output  1  pulse with burst_done when burst_len < 3 (receiver produces no result)
- underrun  output  1  pulse with burst_done when the FIFO emptied before a last-marked word was sent

Behaviour:
- Reset (synchronous, rst=1 at posedge clk), with rst dominant over all other inputs:
  - FIFO count, read pointer and write pointer = 0
  - state = IDLE
  - out_valid=0, out_data=0, busy=0, burst_done=0, burst_len=0, short_burst=0, underrun=0
- Reset mid-burst: out_valid=0 on the next edge and buffered words are discarded. No burst_done pulse.
- Push:
  - Occurs when in_valid && in_ready; stores {in_last, in_data}.
  - A pushed word is poppable from the next cycle.
  - Push and pop in the same cycle are allowed; count is unchanged.
- States: IDLE, SEND, GAP.
- IDLE:
  - out_valid=0.
  - Go to SEND when count >= MIN_START, or when any buffered entry has last=1 (track with a registered pending-last counter).
  - Entering SEND pops the head in that same edge, so out_valid=1 the cycle after the start condition is seen.
- SEND: at each edge one of the following applies.
  - Count > 0: pop the head, out_valid<=1, out_data<=head data, increment the length counter (saturates at all ones).
    - If the popped entry has last=1: go to GAP and pulse burst_done/burst_len with the final length. short_burst if the length < 3.
  - Count = 0 with no last seen: out_valid<=0, go to GAP, pulse burst_done with underrun=1 (plus short_burst if the length < 3).
- Status timing: burst_done, burst_len, short_burst and underrun are all registered.
  - After a last word, the pulse coincides with the cycle that word is on out_data.
  - After an underrun, the pulse coincides with the first idle cycle.
- GAP:
  - out_valid<=0 for exactly one cycle.
  - Length counter cleared.
  - Go to IDLE, which may immediately restart if its start condition holds.
  - Net result: at least one validi=0 cycle between bursts.
- out_data holds its last value when out_valid=0.
- Full FIFO: in_ready=0, so no overwrite is possible. Empty FIFO: no pop is attempted.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- A last-marked word arriving while IDLE with count < MIN_START still starts a burst; the burst may be short.

Decomposition:
- Package mac_stream_pkg:
  - state enum tx_state_t {IDLE, SEND, GAP}
  - localparam MAC_MIN_OPS = 3
  - 32-bit word typedef mac_word_t
  - struct tx_entry_t {logic last; mac_word_t data;}
- Sub-module mac_tx_fifo:
  - Synchronous FIFO of tx_entry_t, DEPTH entries.
  - Outputs: count, head, pending_last.
  - Inputs: push, pop; reset as above.
- The top level contains the FSM, the length counter and the status pulses.

Test Plan:
- Push 2,3,4(last=1) on consecutive cycles -> out_valid=1 for exactly 3 consecutive cycles with out_data 2,3,4; burst_done with burst_len=3, short_burst=0, underrun=0; the receiver yields 10.
- Push 5,6(last) -> 2-word burst 5,6; burst_done with burst_len=2, short_burst=1.
- Push 1,2,3 (no last) then stall the source -> 3 words sent, then out_valid=0; burst_done with underrun=1, burst_len=3.
- DEPTH=4, hold in_valid=1 with the source faster than the drain: 8 words pushed while the FSM is blocked -> in_ready=0 at count=4, no lost or duplicated word, output order matches input order.
- Two back-to-back bursts {1,2,3(last)} {4,5,6(last)} pre-loaded -> exactly one out_valid=0 cycle between 3 and 4; two burst_done pulses, each with len=3.
- Assert rst for one cycle during the second word of a 5-word burst -> next cycle out_valid=0, count=0, no burst_done, in_ready=1.
